// File: rtl/input_bin_ctr_gen.sv
// rtl/input_bin_ctr_gen.sv - per-block radix bin counter, prefix offset and bin write-pointer generator
//
// Purpose: for each accepted block of STREAM_WIDTH {row_idx,value} lanes, count how many valid lanes
// map to each destination unit (radix field of row_idx), emit the exclusive prefix of those counts,
// and the running write base of each unit's bin. Tracks bin occupancy and flags almost-full/overflow.
//
// Ports:
//   clk, rst_b                 clock, synchronous active-low reset
//   in_valid/in_ready          block handshake on din/lane_valid
//   din[SW][DATA_WIDTH]        element lanes, lane_valid[SW] lane mask
//   out_valid/out_ready        result handshake on blk_cnt/blk_base/wr_base
//   blk_cnt[NU], blk_base[NU]  per-unit element count and exclusive prefix offset
//   wr_base[NU]                per-unit bin write pointer for this block
//   clear_ptrs                 zero all write pointers and occupancies
//   unit_pop[NU]               one entry drained from bin u
//   bin_almost_full[NU]        occupancy above BIN_DEPTH-STREAM_WIDTH
//   overflow_err[NU]           sticky bin overflow
module input_bin_ctr_gen #(
  parameter int NUM_UNITS           = 4,
  parameter int BITS_UNIT_SELECTION = 2,
  parameter int UNIT_INIT_BIT       = 0,
  parameter int BITS_ROW_IDX        = 8,
  parameter int DATA_WIDTH          = 16,
  parameter int STREAM_WIDTH        = 8,
  parameter int LOG_STREAM_WIDTH    = 3,
  parameter int BITS_BIN_ADDR       = 4,
  parameter int LATENCY             = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_b,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [STREAM_WIDTH-1:0][DATA_WIDTH-1:0]       din,
  input  logic [STREAM_WIDTH-1:0]                       lane_valid,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_UNITS-1:0][LOG_STREAM_WIDTH:0]      blk_cnt,
  output logic [NUM_UNITS-1:0][LOG_STREAM_WIDTH:0]      blk_base,
  output logic [NUM_UNITS-1:0][BITS_BIN_ADDR-1:0]       wr_base,
  input  logic                                          clear_ptrs,
  input  logic [NUM_UNITS-1:0]                          unit_pop,
  output logic [NUM_UNITS-1:0]                          bin_almost_full,
  output logic [NUM_UNITS-1:0]                          overflow_err
);

  localparam int NU        = NUM_UNITS;
  localparam int SW        = STREAM_WIDTH;
  localparam int LSW       = LOG_STREAM_WIDTH;
  localparam int BU        = BITS_UNIT_SELECTION;
  localparam int BA        = BITS_BIN_ADDR;
  localparam int BIN_DEPTH = 1 << BA;
  localparam int DLY       = LATENCY - LSW - 1;
  localparam int RADIX_LSB = DATA_WIDTH - BITS_ROW_IDX + UNIT_INIT_BIT;
  localparam int OW        = (BA + 2 > LSW + 2) ? BA + 2 : LSW + 2;
  localparam logic [BA:0] OCC_FULL = {1'b1, {BA{1'b0}}};
  localparam logic [BA:0] OCC_AF   = (BA+1)'(BIN_DEPTH - SW);

  logic adv;
  logic fire;
  logic [LATENCY-1:0] vld;

  assign out_valid = vld[LATENCY-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign fire      = out_valid & out_ready;

  // Only the radix field of each element is relevant to counting.
  logic unused_din;
  assign unused_din = ^din;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[LATENCY-2:0], in_valid};
    end
  end

  logic [SW-1:0][BU-1:0] s1_radix;
  logic [SW-1:0]         s1_mask;

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int l = 0; l < SW; l++) begin
        s1_radix[l] <= din[l][RADIX_LSB +: BU];
      end
      s1_mask <= lane_valid;
    end
  end

  // Level 0 holds per-lane match/lower bits; each later level sums adjacent pairs,
  // one level per pipeline stage, so level LSW holds the full popcounts.
  for (genvar j = 0; j <= LSW; j++) begin : g_lvl
    localparam int N = SW >> j;
    logic [NU-1:0][N-1:0][LSW:0] cnt;
    logic [NU-1:0][N-1:0][LSW:0] base;
    if (j == 0) begin : g_leaf
      always_comb begin
        cnt  = '0;
        base = '0;
        for (int u = 0; u < NU; u++) begin
          for (int l = 0; l < SW; l++) begin
            cnt[u][l]  = {{LSW{1'b0}}, s1_mask[l] & (s1_radix[l] == BU'(u))};
            // lower[u] = some unit below u matched, i.e. radix < u
            base[u][l] = {{LSW{1'b0}}, s1_mask[l] & (s1_radix[l] <  BU'(u))};
          end
        end
      end
    end else begin : g_sum
      always_ff @(posedge clk) begin
        if (adv) begin
          for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < N; i++) begin
              cnt[u][i]  <= g_lvl[j-1].cnt[u][2*i]  + g_lvl[j-1].cnt[u][2*i+1];
              base[u][i] <= g_lvl[j-1].base[u][2*i] + g_lvl[j-1].base[u][2*i+1];
            end
          end
        end
      end
    end
  end

  logic [NU-1:0][LSW:0] fin_cnt;
  logic [NU-1:0][LSW:0] fin_base;

  if (DLY == 0) begin : g_nodly
    assign fin_cnt  = g_lvl[LSW].cnt;
    assign fin_base = g_lvl[LSW].base;
  end else begin : g_dly
    logic [DLY-1:0][NU-1:0][LSW:0] dc;
    logic [DLY-1:0][NU-1:0][LSW:0] db;
    always_ff @(posedge clk) begin
      if (adv) begin
        dc[0] <= g_lvl[LSW].cnt;
        db[0] <= g_lvl[LSW].base;
        for (int k = 1; k < DLY; k++) begin
          dc[k] <= dc[k-1];
          db[k] <= db[k-1];
        end
      end
    end
    assign fin_cnt  = dc[DLY-1];
    assign fin_base = db[DLY-1];
  end

  assign blk_cnt  = out_valid ? fin_cnt  : '0;
  assign blk_base = out_valid ? fin_base : '0;

  logic [NU-1:0][BA-1:0] ptr;
  logic [NU-1:0][BA:0]   occ;
  logic [NU-1:0][OW-1:0] occ_sum;

  assign wr_base = ptr;

  always_comb begin
    occ_sum = '0;
    for (int u = 0; u < NU; u++) begin
      // A pop against an empty bin is dropped rather than underflowing.
      occ_sum[u] = OW'(occ[u]) + (fire ? OW'(fin_cnt[u]) : OW'(0))
                 - OW'(unit_pop[u] & (occ[u] != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ptr          <= '0;
      occ          <= '0;
      overflow_err <= '0;
    end else if (clear_ptrs) begin
      ptr <= '0;
      occ <= '0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (fire) begin
          ptr[u] <= ptr[u] + BA'(fin_cnt[u]);
        end
        if (occ_sum[u] > OW'(BIN_DEPTH)) begin
          occ[u]          <= OCC_FULL;
          overflow_err[u] <= 1'b1;
        end else begin
          occ[u] <= occ_sum[u][BA:0];
        end
      end
    end
  end

  always_comb begin
    bin_almost_full = '0;
    for (int u = 0; u < NU; u++) begin
      bin_almost_full[u] = occ[u] > OCC_AF;
    end
  end

endmodule

// File: tb/tb_input_bin_ctr_gen.sv
// tb/tb_input_bin_ctr_gen.sv - scoreboard bench for input_bin_ctr_gen
module tb_input_bin_ctr_gen;

  logic                 clk;
  logic                 rst_b;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0][15:0]     din;
  logic [7:0]           lane_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0][3:0]      blk_cnt;
  logic [3:0][3:0]      blk_base;
  logic [3:0][3:0]      wr_base;
  logic                 clear_ptrs;
  logic [3:0]           unit_pop;
  logic [3:0]           bin_almost_full;
  logic [3:0]           overflow_err;

  input_bin_ctr_gen #(
    .NUM_UNITS(4), .BITS_UNIT_SELECTION(2), .UNIT_INIT_BIT(0), .BITS_ROW_IDX(8),
    .DATA_WIDTH(16), .STREAM_WIDTH(8), .LOG_STREAM_WIDTH(3), .BITS_BIN_ADDR(4), .LATENCY(5)
  ) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .lane_valid(lane_valid), .out_valid(out_valid), .out_ready(out_ready),
    .blk_cnt(blk_cnt), .blk_base(blk_base), .wr_base(wr_base), .clear_ptrs(clear_ptrs),
    .unit_pop(unit_pop), .bin_almost_full(bin_almost_full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][3:0] cnt;
    logic [3:0][3:0] base;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   m_ptr[4];
  int   m_occ[4];
  bit   m_err[4];
  int   fires = 0;
  int   wr1_log[$];
  exp_t mon_e;
  int   mon_n;

  function automatic exp_t model(input logic [7:0][15:0] d, input logic [7:0] m);
    exp_t e;
    int c[4];
    int run;
    e = '0;
    run = 0;
    for (int u = 0; u < 4; u++) c[u] = 0;
    for (int l = 0; l < 8; l++) if (m[l]) c[d[l][9:8]]++;
    for (int u = 0; u < 4; u++) begin
      e.cnt[u]  = 4'(c[u]);
      e.base[u] = 4'(run);
      run += c[u];
    end
    return e;
  endfunction

  function automatic logic [7:0][15:0] mk(input logic [7:0][1:0] rad);
    logic [7:0][15:0] d;
    for (int l = 0; l < 8; l++) d[l] = {6'($urandom), rad[l], 8'($urandom)};
    return d;
  endfunction

  // Scoreboard monitor: samples mid-cycle, models the effect of the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_b) begin
        sb.delete();
        for (int u = 0; u < 4; u++) begin
          m_ptr[u] = 0; m_occ[u] = 0; m_err[u] = 0;
        end
      end else begin
        for (int u = 0; u < 4; u++) begin
          checks++;
          if (bin_almost_full[u] !== (m_occ[u] > 8)) begin
            errors++;
            $display("FAIL mon_almost_full[%0d] t=%0t: got %b expected %b", u, $time, bin_almost_full[u], m_occ[u] > 8);
          end
          checks++;
          if (overflow_err[u] !== m_err[u]) begin
            errors++;
            $display("FAIL mon_overflow[%0d] t=%0t: got %b expected %b", u, $time, overflow_err[u], m_err[u]);
          end
          checks++;
          if (wr_base[u] !== 4'(m_ptr[u])) begin
            errors++;
            $display("FAIL mon_wr_base[%0d] t=%0t: got %0d expected %0d", u, $time, wr_base[u], m_ptr[u]);
          end
        end
        mon_e = '0;
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected_out t=%0t: got out_valid=1 expected no pending block", $time);
          end else begin
            mon_e = sb.pop_front();
            if (blk_cnt !== mon_e.cnt || blk_base !== mon_e.base) begin
              errors++;
              $display("FAIL mon_block t=%0t: got cnt=%h base=%h expected cnt=%h base=%h",
                       $time, blk_cnt, blk_base, mon_e.cnt, mon_e.base);
            end
          end
          fires++;
          wr1_log.push_back(int'(wr_base[1]));
        end
        if (in_valid && in_ready) sb.push_back(model(din, lane_valid));
        if (clear_ptrs) begin
          for (int u = 0; u < 4; u++) begin
            m_ptr[u] = 0; m_occ[u] = 0;
          end
        end else begin
          for (int u = 0; u < 4; u++) begin
            mon_n = m_occ[u] + int'(mon_e.cnt[u]) - ((unit_pop[u] && m_occ[u] > 0) ? 1 : 0);
            m_ptr[u] = (m_ptr[u] + int'(mon_e.cnt[u])) % 16;
            if (mon_n > 16) begin
              mon_n = 16;
              m_err[u] = 1;
            end
            m_occ[u] = mon_n;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 0; lane_valid = '0; unit_pop = '0; clear_ptrs = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_b = 0;
    idle_inputs();
    @(posedge clk); #1;
    rst_b = 1;
  endtask

  task automatic send(input logic [7:0][15:0] d, input logic [7:0] m);
    int n;
    in_valid = 1; din = d; lane_valid = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 30);
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst_b = 0;
    idle_inputs();
    mon_en = 1;
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (blk_cnt !== '0) begin errors++; $display("FAIL reset_blk_cnt: got %h expected 0", blk_cnt); end
    checks++; if (blk_base !== '0) begin errors++; $display("FAIL reset_blk_base: got %h expected 0", blk_base); end
    checks++; if (wr_base !== '0) begin errors++; $display("FAIL reset_wr_base: got %h expected 0", wr_base); end
    checks++; if (overflow_err !== '0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_err); end
    checks++; if (bin_almost_full !== '0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", bin_almost_full); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0][1:0] r;
    int n;
    do_reset();
    r = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    send(mk(r), 8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    checks++; if (n != 5) begin errors++; $display("FAIL single_latency: got %0d cycles expected 5", n); end
    checks++; if (blk_cnt !== {4'd2, 4'd2, 4'd2, 4'd2}) begin errors++; $display("FAIL single_cnt: got %h expected 2222", blk_cnt); end
    checks++; if (blk_base !== {4'd6, 4'd4, 4'd2, 4'd0}) begin errors++; $display("FAIL single_base: got %h expected 6420", blk_base); end
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_mask();
    logic [7:0][1:0] r;
    bit ok;
    do_reset();
    r = {8{2'd3}};
    send(mk(r), 8'h0F);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_0f_timeout: got out_valid=0 expected 1"); end
    checks++; if (blk_cnt !== {4'd4, 4'd0, 4'd0, 4'd0}) begin errors++; $display("FAIL mask_0f_cnt: got %h expected 4000", blk_cnt); end
    checks++; if (blk_base !== '0) begin errors++; $display("FAIL mask_0f_base: got %h expected 0000", blk_base); end
    @(posedge clk); #1;
    send(mk(r), 8'h00);
    wait_out(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_00_valid: got out_valid=0 expected 1"); end
    checks++; if (blk_cnt !== '0) begin errors++; $display("FAIL mask_00_cnt: got %h expected 0000", blk_cnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (wr_base !== {4'd4, 4'd0, 4'd0, 4'd0}) begin errors++; $display("FAIL mask_00_ptrs: got %h expected 4000", wr_base); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [7:0][1:0] r;
    int expv[5];
    do_reset();
    expv = '{0, 8, 0, 8, 0};
    r = {8{2'd1}};
    unit_pop = 4'b0010;
    wr1_log.delete();
    for (int b = 0; b < 5; b++) begin
      send(mk(r), 8'hFF);
      repeat (10) @(posedge clk);
      #1;
    end
    unit_pop = '0;
    checks++; if (wr1_log.size() != 5) begin errors++; $display("FAIL wrap_count: got %0d outputs expected 5", wr1_log.size()); end
    for (int b = 0; b < 5 && b < wr1_log.size(); b++) begin
      checks++;
      if (wr1_log[b] != expv[b]) begin errors++; $display("FAIL wrap_wr_base[%0d]: got %0d expected %0d", b, wr1_log[b], expv[b]); end
    end
    @(negedge clk);
    checks++; if (wr_base !== {4'd0, 4'd0, 4'd8, 4'd0}) begin errors++; $display("FAIL wrap_final: got %h expected 0080", wr_base); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [7:0][1:0] r;
    do_reset();
    r = {8{2'd1}};
    send(mk(r), 8'hFF);
    send(mk(r), 8'hFF);
    repeat (8) @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bin_almost_full !== 4'b0010) begin errors++; $display("FAIL ovf_af_16: got %b expected 0010", bin_almost_full); end
    checks++; if (overflow_err !== 4'b0000) begin errors++; $display("FAIL ovf_err_pre: got %b expected 0000", overflow_err); end
    @(posedge clk); #1;
    send(mk(r), 8'hFF);
    repeat (8) @(posedge clk); #1;
    @(negedge clk);
    checks++; if (overflow_err !== 4'b0010) begin errors++; $display("FAIL ovf_err_set: got %b expected 0010", overflow_err); end
    @(posedge clk); #1;
    unit_pop = 4'b0010;
    repeat (7) @(posedge clk); #1;
    unit_pop = '0;
    @(negedge clk);
    checks++; if (bin_almost_full[1] !== 1'b1) begin errors++; $display("FAIL ovf_clamp_9: got %b expected 1", bin_almost_full[1]); end
    @(posedge clk); #1;
    unit_pop = 4'b0010;
    @(posedge clk); #1;
    unit_pop = '0;
    @(negedge clk);
    checks++; if (bin_almost_full[1] !== 1'b0) begin errors++; $display("FAIL ovf_clamp_8: got %b expected 0", bin_almost_full[1]); end
    checks++; if (overflow_err !== 4'b0010) begin errors++; $display("FAIL ovf_sticky: got %b expected 0010", overflow_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0][1:0] r;
    int f0;
    bit ok;
    do_reset();
    f0 = fires;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          r = 16'($urandom);
          send(mk(r), 8'($urandom));
        end
      end
      begin
        wait_out(ok);
        @(posedge clk); #1;
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall[%0d]: got in_ready=%b out_valid=%b expected 0/1", k, in_ready, out_valid);
          end
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    repeat (12) @(posedge clk); #1;
    checks++; if (fires - f0 != 8) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 8", fires - f0); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb.size()); end

    do_reset();
    r = {8{2'd1}};
    send(mk(r), 8'hFF);
    repeat (8) @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bin_almost_full[1] !== 1'b0) begin errors++; $display("FAIL occ8_af: got %b expected 0", bin_almost_full[1]); end
    @(posedge clk); #1;
    out_ready = 0;
    send(mk(r), 8'h03);
    wait_out(ok);
    @(posedge clk); #1;
    unit_pop = 4'b0010;
    out_ready = 1;
    @(posedge clk); #1;
    unit_pop = '0;
    @(negedge clk);
    checks++; if (bin_almost_full[1] !== 1'b1) begin errors++; $display("FAIL occ9_af: got %b expected 1", bin_almost_full[1]); end
    checks++; if (wr_base[1] !== 4'd10) begin errors++; $display("FAIL occ9_ptr: got %0d expected 10", wr_base[1]); end
    @(posedge clk); #1;

    out_ready = 0;
    r = {8{2'd2}};
    send(mk(r), 8'hFF);
    wait_out(ok);
    @(posedge clk); #1;
    clear_ptrs = 1;
    out_ready = 1;
    @(posedge clk); #1;
    clear_ptrs = 0;
    @(negedge clk);
    checks++; if (wr_base !== '0) begin errors++; $display("FAIL clear_ptrs: got %h expected 0000", wr_base); end
    checks++; if (bin_almost_full !== '0) begin errors++; $display("FAIL clear_occ: got %b expected 0000", bin_almost_full); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_fired: got out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_flight();
    logic [7:0][1:0] r;
    int f0;
    int seen;
    do_reset();
    r = {8{2'd1}};
    for (int b = 0; b < 3; b++) send(mk(r), 8'hFF);
    repeat (10) @(posedge clk); #1;
    @(negedge clk);
    checks++; if (overflow_err[1] !== 1'b1) begin errors++; $display("FAIL rf_pre_err: got %b expected 1", overflow_err[1]); end
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) send(mk(r), 8'hFF);
    f0 = fires;
    rst_b = 0;
    @(posedge clk); #1;
    rst_b = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid: got %b expected 0", out_valid); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0 || fires != f0) begin errors++; $display("FAIL rf_emitted: got %0d valid cycles expected 0", seen); end
    checks++; if (wr_base !== '0) begin errors++; $display("FAIL rf_ptr: got %h expected 0000", wr_base); end
    checks++; if (overflow_err !== '0) begin errors++; $display("FAIL rf_err: got %b expected 0000", overflow_err); end
    checks++; if (bin_almost_full !== '0) begin errors++; $display("FAIL rf_occ: got %b expected 0000", bin_almost_full); end
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 0;
    rst_b = 0;
    din = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_mask();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
